// File: rtl/bwc_pkg.sv
// Shared definitions for burst_write_controller: FSM encoding and AXI4 constants.
package bwc_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } bwc_state_e;

    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [7:0] WSTRB_ALL = 8'hFF;

endpackage

// File: rtl/axi_skid_buffer.sv
// Two-entry registered valid/ready buffer: output register plus one skid slot,
// so in_ready is a flop and never depends combinationally on out_ready.
module axi_skid_buffer #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         in_fire;

    assign in_ready  = !skid_valid_q;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || out_ready) begin
            // Output slot frees up: drain the skid entry first to keep order.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_data_d = in_data;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/burst_write_controller.sv
// AXI4 single-INCR-burst write master (64-bit data). Define BWC_BRESP_ERR_EN to
// report SLVERR/DECERR responses on burst_err; otherwise burst_err is tied low.
module burst_write_controller
    import bwc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [63:0] m_axi_wdata,
    output logic [7:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    input  logic [31:0] start_addr,
    input  logic [7:0]  burst_len,
    input  logic        start_burst,
    input  logic [63:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        busy,
    output logic        burst_done,
    output logic        burst_err,
    output logic [1:0]  state_dbg
);

    bwc_state_e  state_q, state_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [7:0]  awlen_q, awlen_d;
    logic        awvalid_q, awvalid_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last_pushed_q, last_pushed_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        accept_en;
    logic        skid_in_ready;
    logic [64:0] skid_out_data;
    logic        err_hit;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, start_addr[2:0]};

`ifdef BWC_BRESP_ERR_EN
    assign err_hit = (m_axi_bresp == AXI_RESP_SLVERR) || (m_axi_bresp == AXI_RESP_DECERR);
`else
    logic unused_bresp;
    assign unused_bresp = &{1'b0, m_axi_bresp};
    assign err_hit      = 1'b0;
`endif

    // Upstream is only opened in DATA and closed for good once the final beat is in.
    assign accept_en = (state_q == S_DATA) && !last_pushed_q;
    assign s_ready   = accept_en && skid_in_ready;

    axi_skid_buffer #(.W(65)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_valid && accept_en),
        .in_ready  (skid_in_ready),
        .in_data   ({(cnt_q == 8'd0), s_data}),
        .out_valid (m_axi_wvalid),
        .out_ready (m_axi_wready),
        .out_data  (skid_out_data)
    );

    assign m_axi_wdata   = skid_out_data[63:0];
    assign m_axi_wlast   = skid_out_data[64];
    assign m_axi_wstrb   = WSTRB_ALL;
    assign m_axi_awsize  = AXI_SIZE_8B;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_bready  = (state_q == S_RESP);
    assign busy          = (state_q != S_IDLE);
    assign burst_done    = done_q;
    assign burst_err     = err_q;
    assign state_dbg     = state_q;

    always_comb begin
        state_d       = state_q;
        awaddr_d      = awaddr_q;
        awlen_d       = awlen_q;
        awvalid_d     = awvalid_q;
        cnt_d         = cnt_q;
        last_pushed_d = last_pushed_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_burst) begin
                    awaddr_d      = {start_addr[31:3], 3'b000};
                    awlen_d       = burst_len - 8'd1;
                    cnt_d         = burst_len - 8'd1;
                    awvalid_d     = 1'b1;
                    last_pushed_d = 1'b0;
                    state_d       = S_ADDR;
                end
            end
            S_ADDR: begin
                if (m_axi_awready) begin
                    awvalid_d = 1'b0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (s_valid && s_ready) begin
                    if (cnt_q == 8'd0) begin
                        last_pushed_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                if (m_axi_wvalid && m_axi_wready && m_axi_wlast) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (m_axi_bvalid) begin
                    done_d  = 1'b1;
                    err_d   = err_hit;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            awaddr_q      <= '0;
            awlen_q       <= '0;
            awvalid_q     <= 1'b0;
            cnt_q         <= '0;
            last_pushed_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            awaddr_q      <= awaddr_d;
            awlen_q       <= awlen_d;
            awvalid_q     <= awvalid_d;
            cnt_q         <= cnt_d;
            last_pushed_q <= last_pushed_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

endmodule

// File: tb/tb_burst_write_controller.sv
// Directed-plus-random bench for burst_write_controller; expected W stream is the
// list of accepted upstream beats, with AW/B values derived from the burst request.
module tb_burst_write_controller;

    logic        clk;
    logic        rst;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] start_addr;
    logic [7:0]  burst_len;
    logic        start_burst;
    logic [63:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        busy;
    logic        burst_done;
    logic        burst_err;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;
    logic [63:0] data_arr [256];

    burst_write_controller dut (
        .clk           (clk),
        .rst           (rst),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .start_addr    (start_addr),
        .burst_len     (burst_len),
        .start_burst   (start_burst),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .busy          (busy),
        .burst_done    (burst_done),
        .burst_err     (burst_err),
        .state_dbg     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_awaddr"}, m_axi_awaddr, 0);
        check({tag, "_awlen"}, m_axi_awlen, 0);
        check({tag, "_awvalid"}, m_axi_awvalid, 0);
        check({tag, "_wdata"}, m_axi_wdata, 0);
        check({tag, "_wlast"}, m_axi_wlast, 0);
        check({tag, "_wvalid"}, m_axi_wvalid, 0);
        check({tag, "_bready"}, m_axi_bready, 0);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, burst_done, 0);
        check({tag, "_err"}, burst_err, 0);
        check({tag, "_awsize"}, m_axi_awsize, 3'b011);
        check({tag, "_awburst"}, m_axi_awburst, 2'b01);
        check({tag, "_wstrb"}, m_axi_wstrb, 8'hFF);
    endtask

    task automatic fill_data(input int mode);
        for (int i = 0; i < 256; i++) begin
            if (mode == 1) data_arr[i] = 64'(i);
            else           data_arr[i] = {$urandom, $urandom};
        end
    endtask

    // wmode: 0 wready always 1, 1 repeating 1-0-0-1, 2 random.
    // smode: 0 s_valid always 1, 1 random. rnd: random awready/bvalid and stray start_burst.
    // abort_at >= 0 stops driving once that many W beats have been delivered.
    task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input int wmode,
                             input int smode, input int rnd, input logic [1:0] resp,
                             input int abort_at);
        int   n, acc, wb, cyc, first_w, last_w, first_acc;
        logic aw_done, resp_done, stall_p, stall_l, aw_fire, s_fire, resp_fire, exp_err;
        logic [63:0] stall_d;
        logic [31:0] exp_addr;
        logic [7:0]  exp_len;
        logic [3:0]  wpat;
        n        = (len == 8'd0) ? 256 : int'(len);
        exp_addr = addr & 32'hFFFF_FFF8;
        exp_len  = 8'((n - 1) & 255);
        acc = 0; wb = 0; cyc = 0; first_w = 0; last_w = 0; first_acc = 0;
        aw_done = 0; resp_done = 0; stall_p = 0; stall_l = 0; stall_d = '0;
        wpat = 4'b1001;
`ifdef BWC_BRESP_ERR_EN
        exp_err = resp[1];
`else
        exp_err = 1'b0;
`endif
        start_addr  = addr;
        burst_len   = len;
        start_burst = 1'b1;
        @(posedge clk); #1;
        start_burst = 1'b0;
        check("start_awvalid", m_axi_awvalid, 1);
        check("start_busy", busy, 1);

        while (!resp_done && cyc < 4000 && !(abort_at >= 0 && wb >= abort_at)) begin
            if (m_axi_awvalid) begin
                check("awaddr", m_axi_awaddr, exp_addr);
                check("awlen", m_axi_awlen, exp_len);
            end
            if (aw_done) check("awvalid_dropped", m_axi_awvalid, 0);
            else         check("w_before_aw", m_axi_wvalid, 0);
            check("done_early", burst_done, 0);
            m_axi_awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            aw_fire = m_axi_awvalid && m_axi_awready;

            if (acc < n) s_valid = smode ? 1'($urandom_range(0, 1)) : 1'b1;
            else         s_valid = 1'b0;
            s_data = data_arr[acc % 256];
            if (acc >= n) check("s_ready_after_last", s_ready, 0);
            s_fire = s_valid && s_ready;

            // B may only be offered once the whole W stream has been delivered.
            m_axi_bvalid = (wb == n) && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
            m_axi_bresp  = resp;
            if (m_axi_bvalid) check("bready", m_axi_bready, 1);
            resp_fire = m_axi_bvalid && m_axi_bready;

            case (wmode)
                0:       m_axi_wready = 1'b1;
                1:       m_axi_wready = wpat[cyc % 4];
                default: m_axi_wready = 1'($urandom_range(0, 1));
            endcase
            if (stall_p) begin
                check("stall_wvalid", m_axi_wvalid, 1);
                check("stall_wdata", m_axi_wdata, stall_d);
                check("stall_wlast", m_axi_wlast, stall_l);
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (wb < n) begin
                    check("wdata", m_axi_wdata, data_arr[wb]);
                    check("wlast", m_axi_wlast, (wb == n - 1));
                end else begin
                    check("extra_w_beat", 1, 0);
                end
                if (wb == 0) first_w = cyc;
                last_w = cyc;
                wb++;
            end
            stall_p = m_axi_wvalid && !m_axi_wready;
            stall_d = m_axi_wdata;
            stall_l = m_axi_wlast;

            if (rnd) begin
                start_burst = ($urandom_range(0, 3) == 0);
                start_addr  = $urandom;
                burst_len   = 8'($urandom);
            end
            if (s_fire) begin
                if (acc == 0) first_acc = cyc;
                acc++;
            end
            if (aw_fire) aw_done = 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (resp_fire) resp_done = 1'b1;
            start_burst = 1'b0;
        end
        s_valid = 0; m_axi_bvalid = 0; m_axi_wready = 0; m_axi_awready = 0;
        if (abort_at < 0) begin
            check("resp_seen", resp_done, 1);
            check("beats_accepted", acc, n);
            check("beats_written", wb, n);
            check("done_pulse", burst_done, 1);
            check("err_pulse", burst_err, exp_err);
            check("busy_after", busy, 0);
            check("bready_after", m_axi_bready, 0);
            if (wmode == 0 && smode == 0 && !rnd) begin
                check("no_stall_span", last_w - first_w, n - 1);
                check("w_latency", first_w - first_acc, 1);
            end
            @(posedge clk); #1;
            check("done_cleared", burst_done, 0);
            check("err_cleared", burst_err, 0);
        end else begin
            check("abort_reached", wb, abort_at);
        end
    endtask

    initial begin
        rst = 1'b1;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bresp = 0; m_axi_bvalid = 0;
        start_addr = 0; burst_len = 0; start_burst = 0; s_data = 0; s_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // single beat
        data_arr[0] = 64'hDEADBEEF_CAFEF00D;
        run_burst(32'h1000_0000, 8'd1, 0, 0, 0, 2'b00, -1);

        // 16 beats at full rate, data 0..15
        fill_data(1);
        run_burst(32'h2000_0100, 8'd16, 0, 0, 0, 2'b00, -1);

        // backpressure 1-0-0-1 with random upstream
        fill_data(0);
        run_burst(32'h3000_0040, 8'd8, 1, 1, 1, 2'b00, -1);

        // 256-beat burst from an unaligned address
        fill_data(0);
        run_burst(32'h1000_0005, 8'd0, 0, 0, 0, 2'b00, -1);

        // error and non-error responses
        fill_data(0);
        run_burst(32'h4000_0000, 8'd4, 2, 1, 1, 2'b10, -1);
        run_burst(32'h4000_0800, 8'd3, 0, 1, 1, 2'b11, -1);
        run_burst(32'h4000_1000, 8'd2, 0, 0, 1, 2'b01, -1);

        // reset after 3 of 8 beats, then a clean burst
        fill_data(0);
        run_burst(32'h5000_0000, 8'd8, 0, 0, 0, 2'b00, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_values("midreset");
        rst = 1'b0;
        @(posedge clk); #1;
        fill_data(0);
        run_burst(32'h5000_0200, 8'd5, 0, 1, 0, 2'b00, -1);

        // random bursts
        for (int k = 0; k < 6; k++) begin
            fill_data(0);
            run_burst({$urandom_range(0, 32'hFFFF) , 16'h0} | 32'($urandom_range(0, 255)),
                      8'($urandom_range(1, 40)), $urandom_range(0, 2),
                      $urandom_range(0, 1), 1, 2'($urandom_range(0, 3)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/burst_write_controller.md
# burst_write_controller

AXI4 write-burst master for 64-bit memory writes: accepts a start address and beat count, issues one INCR burst on the AW channel, streams beats from an upstream valid/ready source onto the W channel, then waits for the B response. It is the write-side counterpart of the read burst engine and sits between the BFS result/frontier writers and the Zynq HP port interconnect.

## Interface
- No parameters. Data width is fixed at 64 bits; address width is fixed at 32 bits.
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- m_axi_awaddr  out  32  burst address, registered, bits [2:0] forced to 0
- m_axi_awlen  out  8  beats-1, registered
- m_axi_awsize  out  3  constant 3'b011 (8 bytes)
- m_axi_awburst  out  2  constant 2'b01 (INCR)
- m_axi_awvalid  out  1  address valid
- m_axi_awready  in  1  address ready
- m_axi_wdata  out  64  write data, registered
- m_axi_wstrb  out  8  constant 8'hFF
- m_axi_wlast  out  1  last beat, registered with wdata
- m_axi_wvalid  out  1  write valid
- m_axi_wready  in  1  write ready
- m_axi_bresp  in  2  write response
- m_axi_bvalid  in  1  response valid
- m_axi_bready  out  1  response ready
- start_addr  in  32  burst start address (8-byte aligned)
- burst_len  in  8  beat count; 1..255 literal, 0 = 256 beats
- start_burst  in  1  start request, sampled only in IDLE
- s_data  in  64  upstream beat data
- s_valid  in  1  upstream beat valid
- s_ready  out  1  upstream beat accepted when s_valid & s_ready
- busy  out  1  high whenever state != IDLE
- burst_done  out  1  one-cycle pulse on completion
- burst_err  out  1  one-cycle pulse with burst_done on error response (see Configuration)

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: when start_burst = 1, latch awaddr = {start_addr[31:3], 3'b000} and awlen = burst_len - 1 (8-bit wrap, so 0 → 255). Load beat counter = awlen, assert awvalid, and go to ADDR.
- ADDR: hold awvalid, awaddr, and awlen stable until awready. On the handshake, drop awvalid and go to DATA. W is never driven before AW completes.
- DATA: s_ready = skid-buffer input ready. Each accepted upstream beat is pushed with last = (counter == 0); otherwise the counter decrements. After the last beat is pushed, s_ready is held 0. Go to RESP when the W handshake with wlast = 1 occurs.
- RESP: bready = 1. On bvalid, pulse burst_done next cycle, deassert bready, and return to IDLE.
- start_burst outside IDLE is ignored.
- s_valid may toggle freely; wvalid gaps are allowed.
- Burst must not cross a 4 KB boundary; this is the caller's responsibility and is not checked.
- Reset at any point returns to IDLE, flushes the skid buffer, and drops all valids/readies. The interconnect is reset in the same domain.
- Reset values: awaddr = 0, awlen = 0, awvalid = 0, wdata = 0, wlast = 0, wvalid = 0, bready = 0, s_ready = 0, busy = 0, burst_done = 0, burst_err = 0.

## Timing
- start_burst in cycle T → awvalid = 1 and busy = 1 in T+1.
- AW handshake in cycle A → s_ready may be 1 in A+1.
- Upstream beat accepted in cycle D → wvalid with that data in D+1 (one-cycle latency).
- Full throughput with wready held high: one beat per cycle, so N beats take N+1 cycles from the first s_valid.
- wready low: the skid buffer absorbs one extra beat, then s_ready falls in the next cycle. wvalid/wdata/wlast stay stable until the handshake.
- bvalid & bready in cycle R → burst_done = 1 in R+1, state = IDLE in R+1. A new start_burst is accepted in R+1.
- bvalid arriving before RESP is not legal AXI and is not handled.

## Configuration
- BWC_BRESP_ERR_EN defined: burst_err = 1 in the burst_done cycle when the captured bresp[1] = 1 (SLVERR or DECERR).
- BWC_BRESP_ERR_EN undefined: burst_err is tied to 0 and bresp is ignored. All other behaviour is identical.

## Structure
- Shared package bwc_pkg holds:
  - state encoding (2-bit)
  - AXI_SIZE_8B = 3'b011
  - AXI_BURST_INCR = 2'b01
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR
  - WSTRB_ALL = 8'hFF
- One sub-module: axi_skid_buffer, a 2-entry registered valid/ready buffer, 65 bits wide ({last, data}). It drives wvalid/wdata/wlast and provides s_ready.

## Test plan
- Single beat: start_addr = 0x1000_0000, burst_len = 1, one beat 0xDEADBEEF_CAFEF00D, wready/awready/bvalid always 1 → awlen = 0; one W beat with wlast = 1; burst_done pulses once; busy low afterwards.
- 16-beat full rate: burst_len = 16, data 0..15 back-to-back, wready = 1 → awlen = 15; 16 consecutive W beats in order; wlast only on beat 15; no stall cycles.
- Backpressure: burst_len = 8, wready toggles 1-0-0-1 pattern, s_valid random → all 8 beats delivered in order; wdata stable while wvalid & !wready; no beat lost or duplicated.
- Edge length: burst_len = 0 → awlen = 255, exactly 256 W beats, wlast on the 256th; unaligned start_addr 0x1000_0005 yields awaddr 0x1000_0000.
- Error response (macro on): bresp = 2'b10 → burst_err and burst_done pulse together. With the macro off, burst_err stays 0.
- Reset mid-burst: assert rst after 3 of 8 beats → all outputs at reset values next cycle. A start_burst issued after reset completes a clean new burst.
